// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master round-robin arbiter in front of the shared slave bus.
// Serialises one read or write at a time, returns read data to the owning
// master, and force-completes reads whose slave never answers.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   m0_* / m1_*               master request side (addr, rd_en, wr_en, wr_data,
//                             wr_mask in; rd_data, rd_valid, ack out)
//   s_*                       slave side (addr, strobes, write data/mask out;
//                             rd_data, rd_valid in)
//   busy                      high whenever the arbiter is not idle
//   err                       sticky read-timeout flag
module bus_arbiter #(
  parameter int unsigned AW      = 16,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] m0_addr,
  input  logic          m0_rd_en,
  input  logic          m0_wr_en,
  input  logic [31:0]   m0_wr_data,
  input  logic [3:0]    m0_wr_mask,
  output logic [31:0]   m0_rd_data,
  output logic          m0_rd_valid,
  output logic          m0_ack,
  input  logic [AW-1:0] m1_addr,
  input  logic          m1_rd_en,
  input  logic          m1_wr_en,
  input  logic [31:0]   m1_wr_data,
  input  logic [3:0]    m1_wr_mask,
  output logic [31:0]   m1_rd_data,
  output logic          m1_rd_valid,
  output logic          m1_ack,
  output logic [AW-1:0] s_addr,
  output logic          s_rd_en,
  output logic          s_wr_en,
  output logic [31:0]   s_wr_data,
  output logic [3:0]    s_wr_mask,
  input  logic [31:0]   s_rd_data,
  input  logic          s_rd_valid,
  output logic          busy,
  output logic          err
);

  localparam int unsigned CW = 8;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t        state, state_nxt;
  logic          gnt, gnt_nxt;
  logic          last_gnt, last_gnt_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  logic [AW-1:0] s_addr_nxt;
  logic          s_rd_en_nxt, s_wr_en_nxt;
  logic [31:0]   s_wr_data_nxt;
  logic [3:0]    s_wr_mask_nxt;
  logic [31:0]   m0_rd_data_nxt, m1_rd_data_nxt;
  logic          m0_rd_valid_nxt, m1_rd_valid_nxt;
  logic          m0_ack_nxt, m1_ack_nxt;
  logic          busy_nxt, err_nxt;

  // Request decode and round-robin pick (1 = master 1)
  logic req0_c, req1_c, pick_c, pick_wr_c;
  assign req0_c    = m0_rd_en | m0_wr_en;
  assign req1_c    = m1_rd_en | m1_wr_en;
  assign pick_c    = (req0_c & req1_c) ? ~last_gnt : req1_c;
  assign pick_wr_c = pick_c ? m1_wr_en : m0_wr_en;

  // Read completion: data for the current owner (either slave data or 0 on timeout)
  logic        done_c;
  logic [31:0] done_data_c;

  // Next-state and next-output logic
  always_comb begin
    state_nxt       = state;
    gnt_nxt         = gnt;
    last_gnt_nxt    = last_gnt;
    cnt_nxt         = cnt;
    s_addr_nxt      = s_addr;
    s_wr_data_nxt   = s_wr_data;
    s_wr_mask_nxt   = s_wr_mask;
    s_rd_en_nxt     = 1'b0;
    s_wr_en_nxt     = 1'b0;
    m0_rd_data_nxt  = m0_rd_data;
    m1_rd_data_nxt  = m1_rd_data;
    m0_rd_valid_nxt = 1'b0;
    m1_rd_valid_nxt = 1'b0;
    m0_ack_nxt      = 1'b0;
    m1_ack_nxt      = 1'b0;
    err_nxt         = err;
    done_c          = 1'b0;
    done_data_c     = 32'h0;

    unique case (state)
      IDLE: begin
        if (req0_c | req1_c) begin
          gnt_nxt       = pick_c;
          last_gnt_nxt  = pick_c;
          s_addr_nxt    = pick_c ? m1_addr    : m0_addr;
          s_wr_data_nxt = pick_c ? m1_wr_data : m0_wr_data;
          s_wr_mask_nxt = pick_c ? m1_wr_mask : m0_wr_mask;
          s_wr_en_nxt   = pick_wr_c;
          s_rd_en_nxt   = ~pick_wr_c;
          // Write ack is visible in the same cycle as the slave strobe
          m0_ack_nxt    = pick_wr_c & ~pick_c;
          m1_ack_nxt    = pick_wr_c & pick_c;
          state_nxt     = ISSUE;
        end
      end
      ISSUE: begin
        if (s_wr_en) begin
          state_nxt = IDLE;
        end else if (s_rd_valid) begin
          done_c      = 1'b1;
          done_data_c = s_rd_data;
        end else begin
          cnt_nxt   = '0;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        cnt_nxt = cnt + CW'(1);
        if (s_rd_valid) begin
          done_c      = 1'b1;
          done_data_c = s_rd_data;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          done_c  = 1'b1;
          err_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (done_c) begin
      state_nxt = IDLE;
      if (gnt) begin
        m1_rd_data_nxt  = done_data_c;
        m1_rd_valid_nxt = 1'b1;
      end else begin
        m0_rd_data_nxt  = done_data_c;
        m0_rd_valid_nxt = 1'b1;
      end
    end

    busy_nxt = (state_nxt != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      gnt         <= 1'b0;
      last_gnt    <= 1'b1;
      cnt         <= '0;
      s_addr      <= '0;
      s_rd_en     <= 1'b0;
      s_wr_en     <= 1'b0;
      s_wr_data   <= 32'h0;
      s_wr_mask   <= 4'h0;
      m0_rd_data  <= 32'h0;
      m1_rd_data  <= 32'h0;
      m0_rd_valid <= 1'b0;
      m1_rd_valid <= 1'b0;
      m0_ack      <= 1'b0;
      m1_ack      <= 1'b0;
      busy        <= 1'b0;
      err         <= 1'b0;
    end else begin
      state       <= state_nxt;
      gnt         <= gnt_nxt;
      last_gnt    <= last_gnt_nxt;
      cnt         <= cnt_nxt;
      s_addr      <= s_addr_nxt;
      s_rd_en     <= s_rd_en_nxt;
      s_wr_en     <= s_wr_en_nxt;
      s_wr_data   <= s_wr_data_nxt;
      s_wr_mask   <= s_wr_mask_nxt;
      m0_rd_data  <= m0_rd_data_nxt;
      m1_rd_data  <= m1_rd_data_nxt;
      m0_rd_valid <= m0_rd_valid_nxt;
      m1_rd_valid <= m1_rd_valid_nxt;
      m0_ack      <= m0_ack_nxt;
      m1_ack      <= m1_ack_nxt;
      busy        <= busy_nxt;
      err         <= err_nxt;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed checks of bus_arbiter (single transactions from a
// vector table, then timeout, reset-in-flight and round-robin sequences).
module tb_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] m0_addr, m1_addr;
  logic        m0_rd_en, m0_wr_en, m1_rd_en, m1_wr_en;
  logic [31:0] m0_wr_data, m1_wr_data;
  logic [3:0]  m0_wr_mask, m1_wr_mask;
  logic [31:0] m0_rd_data, m1_rd_data;
  logic        m0_rd_valid, m1_rd_valid, m0_ack, m1_ack;
  logic [15:0] s_addr;
  logic        s_rd_en, s_wr_en;
  logic [31:0] s_wr_data;
  logic [3:0]  s_wr_mask;
  logic [31:0] s_rd_data;
  logic        s_rd_valid;
  logic        busy, err;

  int total = 0;
  int bad   = 0;

  bus_arbiter #(.AW(16), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .m0_addr(m0_addr), .m0_rd_en(m0_rd_en), .m0_wr_en(m0_wr_en),
    .m0_wr_data(m0_wr_data), .m0_wr_mask(m0_wr_mask),
    .m0_rd_data(m0_rd_data), .m0_rd_valid(m0_rd_valid), .m0_ack(m0_ack),
    .m1_addr(m1_addr), .m1_rd_en(m1_rd_en), .m1_wr_en(m1_wr_en),
    .m1_wr_data(m1_wr_data), .m1_wr_mask(m1_wr_mask),
    .m1_rd_data(m1_rd_data), .m1_rd_valid(m1_rd_valid), .m1_ack(m1_ack),
    .s_addr(s_addr), .s_rd_en(s_rd_en), .s_wr_en(s_wr_en),
    .s_wr_data(s_wr_data), .s_wr_mask(s_wr_mask),
    .s_rd_data(s_rd_data), .s_rd_valid(s_rd_valid),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        m;
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    int          delay;
    logic [31:0] rdata;
    logic        exp_swr;
    logic        exp_srd;
    logic        exp_ack0;
    logic        exp_ack1;
    logic        exp_rv0;
    logic        exp_rv1;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_masters();
    m0_rd_en = 0; m0_wr_en = 0; m1_rd_en = 0; m1_wr_en = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_masters();
    s_rd_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle_masters();
    m0_addr = '0; m1_addr = '0;
    m0_wr_data = '0; m1_wr_data = '0;
    m0_wr_mask = '0; m1_wr_mask = '0;
    s_rd_data = '0; s_rd_valid = 1'b0;

    //          m  rd wr addr      wdata         mask dly rdata         swr srd a0 a1 rv0 rv1 exp_rdata
    vecs[0] = '{1'b0, 1'b0, 1'b1, 16'h0010, 32'h12345678, 4'hF, 0, 32'h0,
                1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 16'h8004, 32'h0, 4'h0, 2, 32'hCAFEF00D,
                1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'hCAFEF00D};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 16'h4000, 32'hA5A5A5A5, 4'h3, 0, 32'h0,
                1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 16'h0100, 32'h0, 4'h0, 0, 32'h11223344,
                1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h11223344};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 16'h2222, 32'hDEADBEEF, 4'h8, 0, 32'h0,
                1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 16'h0004, 32'h0, 4'h0, 5, 32'h0BADC0DE,
                1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0BADC0DE};

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_strobes", {30'h0, s_rd_en, s_wr_en}, 32'h0);
    chk("rst_s_addr", 32'(s_addr), 32'h0);
    chk("rst_pulses", {28'h0, m0_rd_valid, m1_rd_valid, m0_ack, m1_ack}, 32'h0);
    chk("rst_rd_data", m0_rd_data | m1_rd_data, 32'h0);
    rst = 1'b0;

    // Single transactions from the table
    for (int i = 0; i < 6; i++) begin
      idle_masters();
      if (vecs[i].m) begin
        m1_addr = vecs[i].addr; m1_rd_en = vecs[i].rd; m1_wr_en = vecs[i].wr;
        m1_wr_data = vecs[i].wdata; m1_wr_mask = vecs[i].mask;
      end else begin
        m0_addr = vecs[i].addr; m0_rd_en = vecs[i].rd; m0_wr_en = vecs[i].wr;
        m0_wr_data = vecs[i].wdata; m0_wr_mask = vecs[i].mask;
      end
      @(negedge clk);
      chk($sformatf("v%0d_s_wr_en", i), 32'(s_wr_en), 32'(vecs[i].exp_swr));
      chk($sformatf("v%0d_s_rd_en", i), 32'(s_rd_en), 32'(vecs[i].exp_srd));
      chk($sformatf("v%0d_s_addr", i), 32'(s_addr), 32'(vecs[i].addr));
      chk($sformatf("v%0d_m0_ack", i), 32'(m0_ack), 32'(vecs[i].exp_ack0));
      chk($sformatf("v%0d_m1_ack", i), 32'(m1_ack), 32'(vecs[i].exp_ack1));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'h1);
      if (vecs[i].exp_swr) begin
        chk($sformatf("v%0d_s_wr_data", i), s_wr_data, vecs[i].wdata);
        chk($sformatf("v%0d_s_wr_mask", i), 32'(s_wr_mask), 32'(vecs[i].mask));
      end
      if (vecs[i].wr) begin
        idle_masters();
        @(negedge clk);
        chk($sformatf("v%0d_post_wr", i), {29'h0, s_wr_en, m0_ack, m1_ack}, 32'h0);
        chk($sformatf("v%0d_post_busy", i), 32'(busy), 32'h0);
      end else begin
        for (int k = 0; k < vecs[i].delay; k++) begin
          @(negedge clk);
          chk($sformatf("v%0d_wait%0d", i, k), {29'h0, s_rd_en, m0_rd_valid, m1_rd_valid}, 32'h0);
        end
        s_rd_valid = 1'b1;
        s_rd_data  = vecs[i].rdata;
        @(negedge clk);
        s_rd_valid = 1'b0;
        idle_masters();
        chk($sformatf("v%0d_m0_rv", i), 32'(m0_rd_valid), 32'(vecs[i].exp_rv0));
        chk($sformatf("v%0d_m1_rv", i), 32'(m1_rd_valid), 32'(vecs[i].exp_rv1));
        chk($sformatf("v%0d_rd_data", i), vecs[i].m ? m1_rd_data : m0_rd_data, vecs[i].exp_rdata);
        chk($sformatf("v%0d_rd_busy", i), 32'(busy), 32'h0);
        @(negedge clk);
        chk($sformatf("v%0d_rv_pulse", i), {30'h0, m0_rd_valid, m1_rd_valid}, 32'h0);
      end
    end

    // Timeout: m0 read, slave silent; m0_rd_data holds 0x11223344 beforehand
    m0_addr = 16'h0300; m0_rd_en = 1'b1;
    @(negedge clk);
    chk("to_strobe", 32'(s_rd_en), 32'h1);
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      chk($sformatf("to_wait%0d", k), {30'h0, m0_rd_valid, err}, 32'h0);
    end
    @(negedge clk);
    chk("to_rv", 32'(m0_rd_valid), 32'h1);
    chk("to_data", m0_rd_data, 32'h0);
    chk("to_err", 32'(err), 32'h1);
    chk("to_busy", 32'(busy), 32'h0);
    m0_rd_en   = 1'b0;
    s_rd_valid = 1'b1;
    s_rd_data  = 32'hFFFFFFFF;
    @(negedge clk);
    s_rd_valid = 1'b0;
    chk("late_rv", {30'h0, m0_rd_valid, m1_rd_valid}, 32'h0);
    @(negedge clk);
    chk("late_rv2", {30'h0, m0_rd_valid, m1_rd_valid}, 32'h0);
    chk("late_data", m0_rd_data, 32'h0);
    chk("late_err", 32'(err), 32'h1);

    // Reset during WAIT of an m1 read
    m1_addr = 16'h0500; m1_rd_en = 1'b1;
    @(negedge clk);
    chk("rw_strobe", 32'(s_rd_en), 32'h1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m1_rd_en = 1'b0;
    chk("rw_busy", 32'(busy), 32'h0);
    chk("rw_err", 32'(err), 32'h0);
    chk("rw_rv", 32'(m1_rd_valid), 32'h0);
    chk("rw_strb", 32'(s_rd_en), 32'h0);
    s_rd_valid = 1'b1;
    s_rd_data  = 32'h77777777;
    @(negedge clk);
    s_rd_valid = 1'b0;
    chk("rw_rv2", {30'h0, m0_rd_valid, m1_rd_valid}, 32'h0);
    m0_addr = 16'h0600; m0_wr_data = 32'h55AA55AA; m0_wr_mask = 4'hF; m0_wr_en = 1'b1;
    @(negedge clk);
    m0_wr_en = 1'b0;
    chk("rw_wr_en", 32'(s_wr_en), 32'h1);
    chk("rw_ack", {30'h0, m0_ack, m1_ack}, 32'h2);
    chk("rw_addr", 32'(s_addr), 32'h0600);
    chk("rw_wdata", s_wr_data, 32'h55AA55AA);

    // Both masters hold reads from reset; slave answers 1 cycle after strobe
    do_reset();
    m0_addr = 16'h1000; m1_addr = 16'h2000;
    m0_rd_en = 1'b1; m1_rd_en = 1'b1;
    for (int t = 0; t < 4; t++) begin
      int n;
      n = 0;
      while (s_rd_en !== 1'b1 && n < 8) begin
        @(negedge clk);
        n++;
      end
      chk($sformatf("alt%0d_strobe", t), 32'(s_rd_en), 32'h1);
      chk($sformatf("alt%0d_addr", t), 32'(s_addr), (t % 2 == 0) ? 32'h1000 : 32'h2000);
      @(negedge clk);
      s_rd_valid = 1'b1;
      s_rd_data  = 32'hA0000000 + 32'(t);
      @(negedge clk);
      s_rd_valid = 1'b0;
      chk($sformatf("alt%0d_rv", t), {30'h0, m0_rd_valid, m1_rd_valid},
          (t % 2 == 0) ? 32'h2 : 32'h1);
      chk($sformatf("alt%0d_data", t), (t % 2 == 0) ? m0_rd_data : m1_rd_data,
          32'hA0000000 + 32'(t));
    end
    idle_masters();
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
